mod_n_serial_check: RTL
=======================

MOD_N_SERIAL_CHECK -- requirements
Module: mod_n_serial_check

Interface
REQ-001 SHALL have parameter DIVISOR, default 5, meaning the modulus; legal range 2..1024.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the frame bit counter.
REQ-003 SHALL have localparam RW = $clog2(DIVISOR), meaning the remainder width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 bit_valid_i  input  1  bit_i, sof_i and eof_i are qualified this cycle.
REQ-007 bit_i  input  1  serial data bit.
REQ-008 sof_i  input  1  first bit of a frame; only meaningful with bit_valid_i.
REQ-009 eof_i  input  1  last bit of a frame; only meaningful with bit_valid_i.
REQ-010 rem_o  output  RW  running remainder of the current frame (registered).
REQ-011 busy_o  output  1  a frame is open (sof accepted, eof not yet accepted).
REQ-012 result_valid_o  output  1  one-cycle pulse: frame result available.
REQ-013 result_div_o  output  1  1 = last completed frame value divisible by DIVISOR; held until next result.
REQ-014 bit_cnt_o  output  CNT_W  bits accepted in current/last frame, saturating at all-ones.
REQ-015 proto_err_o  output  1  one-cycle pulse on a framing violation.

Function
REQ-016 FSM states SHALL be IDLE, ACTIVE, DONE; DONE lasts exactly one cycle and drives result_valid_o=1.
REQ-017 IDLE/DONE + bit_valid_i&sof_i&!eof_i -> ACTIVE; + bit_valid_i&sof_i&eof_i -> DONE; otherwise -> IDLE.
REQ-018 ACTIVE + bit_valid_i&eof_i -> DONE; bit_valid_i=0 -> stay ACTIVE with no state change (gaps allowed).
REQ-019 Accepted bit with sof_i SHALL compute from remainder 0; otherwise from rem_o.
REQ-020 MSB-first update SHALL be r' = 2*r + bit, minus DIVISOR if r' >= DIVISOR; single conditional subtract, no divider.
REQ-021 result_div_o SHALL be loaded with (final remainder == 0) on the same edge that enters DONE.
REQ-022 Latency: result_valid_o SHALL be high the cycle after the eof bit is sampled.
REQ-023 bit_cnt_o SHALL load 1 on an sof bit, increment per further accepted bit, saturate, and hold after DONE until next sof.
REQ-024 bit_valid_i without sof_i in IDLE/DONE SHALL be ignored and pulse proto_err_o the next cycle.
REQ-025 sof_i in ACTIVE SHALL abandon the open frame without a result, restart with that bit, and pulse proto_err_o.
REQ-026 eof_i without sof_i in IDLE SHALL be ignored (per REQ-024); no result_valid_o.
REQ-027 busy_o SHALL equal (state == ACTIVE).

Reset
REQ-028 With rst_n=0 at a clock edge: state=IDLE, rem_o=0, result_valid_o=0, result_div_o=0, bit_cnt_o=0, proto_err_o=0.
REQ-029 Reset mid-frame SHALL discard the frame; no result_valid_o pulse follows.

Configuration
REQ-030 Macro MOD_CHECK_LSB_FIRST_EN defined: frames are LSB-first; weight register w (RW bits) loads 1 mod DIVISOR on sof; r' = (r + bit*w) mod N, w' = (2*w) mod N, each a single conditional subtract.
REQ-031 Macro undefined: MSB-first per REQ-020; no weight register is instantiated.

Verification
REQ-032 DIVISOR=5, MSB-first, bits 1,0,1,0 (sof on first, eof on last) -> rem_o 1,2,0,0; result_valid_o pulse; result_div_o=1; bit_cnt_o=4.
REQ-033 DIVISOR=5, bits 1,1,1 (7) -> result_div_o=0, rem_o=2; then single bit 0 with sof&eof -> next-cycle pulse, result_div_o=1, bit_cnt_o=1.
REQ-034 DIVISOR=5, frame 1,1 then sof on bits 1,0,1,0 -> proto_err_o pulse; single result with result_div_o=1, bit_cnt_o=4.
REQ-035 DIVISOR=7, bits 1,1,1 with 3 idle cycles between each bit (7) -> busy_o high throughout, result_div_o=1.
REQ-036 rst_n low for 1 cycle after 2 bits of a frame -> all outputs 0, no result pulse; stray bit_valid_i afterwards -> proto_err_o pulse.
REQ-037 MOD_CHECK_LSB_FIRST_EN, DIVISOR=3, bits 0,1,1 (6) -> result_div_o=1; bits 1,0,1 (5) -> result_div_o=0, rem_o=2.

Source files
------------

// File: rtl/mod_n_serial_check.sv
// Serial modulo-DIVISOR checker: folds framed serial bits into a running remainder.
// Bit order is MSB-first by default; define MOD_CHECK_LSB_FIRST_EN for LSB-first frames.
module mod_n_serial_check #(
    parameter int DIVISOR = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    input  logic             sof_i,
    input  logic             eof_i,
    output logic [$clog2(DIVISOR)-1:0] rem_o,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic             result_div_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             proto_err_o
);
    localparam int RW = $clog2(DIVISOR);
    localparam logic [RW:0] DIV_EXT = (RW+1)'(DIVISOR);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             perr_q, perr_d;

    logic             start;
    logic             accept;
    logic [RW-1:0]    rem_base;
    logic [RW:0]      rem_sum;
    logic [RW-1:0]    rem_next;

    always_comb begin
        start    = bit_valid_i & sof_i;
        accept   = start | (bit_valid_i & (state_q == ST_ACTIVE));
        // An sof bit always starts from an empty remainder, even when abandoning a frame.
        rem_base = start ? '0 : rem_q;
    end

`ifdef MOD_CHECK_LSB_FIRST_EN
    logic [RW-1:0] w_q, w_d;
    logic [RW-1:0] w_base;
    logic [RW:0]   w_sum;
    logic [RW-1:0] w_next;

    always_comb begin
        w_base   = start ? RW'(1) : w_q;
        rem_sum  = {1'b0, rem_base} + (bit_i ? {1'b0, w_base} : '0);
        rem_next = (rem_sum >= DIV_EXT) ? RW'(rem_sum - DIV_EXT) : rem_sum[RW-1:0];
        w_sum    = {w_base, 1'b0};
        w_next   = (w_sum >= DIV_EXT) ? RW'(w_sum - DIV_EXT) : w_sum[RW-1:0];
        w_d      = accept ? w_next : w_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end
`else
    always_comb begin
        rem_sum  = {rem_base, bit_i};
        rem_next = (rem_sum >= DIV_EXT) ? RW'(rem_sum - DIV_EXT) : rem_sum[RW-1:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        perr_d  = 1'b0;

        case (state_q)
            ST_ACTIVE: begin
                if (bit_valid_i) begin
                    perr_d = sof_i;
                    if (eof_i) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = eof_i ? ST_DONE : ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                    perr_d  = bit_valid_i;
                end
            end
        endcase

        if (accept) begin
            rem_d = rem_next;
            if (start) begin
                cnt_d = CNT_W'(1);
            end else if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (eof_i) begin
                div_d = (rem_next == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            perr_q  <= perr_d;
        end
    end

    assign rem_o          = rem_q;
    assign busy_o         = (state_q == ST_ACTIVE);
    assign result_valid_o = (state_q == ST_DONE);
    assign result_div_o   = div_q;
    assign bit_cnt_o      = cnt_q;
    assign proto_err_o    = perr_q;

endmodule
